// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 2-digit score display path.
// Mode encodings, saturation limit and conversion FSM states.
package seg_disp_pkg;

   localparam logic [1:0] MODE_SCORE    = 2'd0;
   localparam logic [1:0] MODE_TIME     = 2'd1;
   localparam logic [1:0] MODE_ALT      = 2'd2;
   localparam logic [1:0] MODE_GAMEOVER = 2'd3;

   localparam int MAX_VAL = 99;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary (<=99) to two BCD digits.
// One shift per clock; result is published only when complete.
module bin2bcd_seq
   import seg_disp_pkg::*;
#(
   parameter int BIN_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [7:0]       bcd_out
);

   localparam int CW = $clog2(BIN_W);

   state_t           state_q, state_d;
   logic [BIN_W-1:0] sh_q;
   logic [7:0]       bcd_q;
   logic [CW-1:0]    cnt_q;
   logic [7:0]       adj;
   logic [7:0]       shifted;
   logic             last;

   assign last = (cnt_q == CW'(BIN_W - 1));
   assign busy = (state_q == LOAD) || (state_q == SHIFT);
   assign done = (state_q == DONE);

   // Add-3 correction on each digit, then shift in the next binary bit
   always_comb begin
      adj = bcd_q;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      shifted = {adj[6:0], sh_q[BIN_W-1]};
   end

   // Conversion state sequencing
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD:  state_d = SHIFT;
         SHIFT: if (last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers; bcd_out is written only with the final result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         bcd_out <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            LOAD: begin
               sh_q  <= bin_in;
               bcd_q <= '0;
               cnt_q <= '0;
            end
            SHIFT: begin
               bcd_q <= shifted;
               sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
               if (last) bcd_out <= shifted;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/score_display_ctrl.sv
// Display sequencer: source select, alternate dwell, blink,
// change detection and BCD conversion hand-off to the scanner.
module score_display_ctrl
   import seg_disp_pkg::*;
#(
   parameter int BIN_W       = 7,
   parameter int ALT_TICKS   = 2000,
   parameter int BLINK_TICKS = 500,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [BIN_W-1:0] score_bin,
   input  logic [BIN_W-1:0] time_bin,
   input  logic [1:0]       mode,
   output logic [7:0]       bcd_out,
   output logic             blank,
   output logic             lz_blank,
   output logic             src_sel,
   output logic             busy,
   output logic             upd_valid
);

   localparam int DW = $clog2(ALT_TICKS);
   localparam int BW = $clog2(BLINK_TICKS);

   logic [DW-1:0]    dwell_q;
   logic [BW-1:0]    blink_q;
   logic [BIN_W-1:0] sel, val;
   logic [BIN_W-1:0] last_val, cap_val;
   logic             last_src, cap_src;
   logic             start, accept, done;

   assign sel   = src_sel ? time_bin : score_bin;
   assign val   = (sel > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : sel;
   assign start = (val != last_val) || (src_sel != last_src);
   assign accept = start && !busy && !done;

   assign upd_valid = done;
   assign lz_blank  = (LZ_SUPPRESS != 0) && (bcd_out[7:4] == 4'd0);

   // Source select and alternate-mode dwell timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_sel <= 1'b0;
         dwell_q <= '0;
      end else begin
         unique case (mode)
            MODE_SCORE, MODE_GAMEOVER: begin
               src_sel <= 1'b0;
               dwell_q <= '0;
            end
            MODE_TIME: begin
               src_sel <= 1'b1;
               dwell_q <= '0;
            end
            MODE_ALT: begin
               if (tick) begin
                  if (dwell_q == DW'(ALT_TICKS - 1)) begin
                     dwell_q <= '0;
                     src_sel <= ~src_sel;
                  end else begin
                     dwell_q <= dwell_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Game-over blink: toggle blank every BLINK_TICKS ticks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank   <= 1'b0;
         blink_q <= '0;
      end else if (mode != MODE_GAMEOVER) begin
         blank   <= 1'b0;
         blink_q <= '0;
      end else if (tick) begin
         if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_q <= '0;
            blank   <= ~blank;
         end else begin
            blink_q <= blink_q + 1'b1;
         end
      end
   end

   // Track what is being converted and what was last published
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_val  <= '0;
         cap_src  <= 1'b0;
         last_val <= '0;
         last_src <= 1'b0;
      end else begin
         if (accept) begin
            cap_val <= val;
            cap_src <= src_sel;
         end
         if (done) begin
            last_val <= cap_val;
            last_src <= cap_src;
         end
      end
   end

   bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (cap_val),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
   );

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl.
// Expected BCD words are queued by stimulus and popped on upd_valid.
module tb_score_display_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [6:0] score_bin;
   logic [6:0] time_bin;
   logic [1:0] mode;
   logic [7:0] bcd_out;
   logic       blank, lz_blank, src_sel, busy, upd_valid;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] e_bcd;
   int         lat;
   logic       exp_src;
   logic       exp_blank;
   int         tcnt;

   always #5 clk = ~clk;

   score_display_ctrl #(
      .BIN_W(7), .ALT_TICKS(4), .BLINK_TICKS(3), .LZ_SUPPRESS(1)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .score_bin(score_bin), .time_bin(time_bin), .mode(mode),
      .bcd_out(bcd_out), .blank(blank), .lz_blank(lz_blank),
      .src_sel(src_sel), .busy(busy), .upd_valid(upd_valid)
   );

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_upd(output int l);
      l = 0;
      do begin
         @(posedge clk);
         l++;
         #1;
      end while (!upd_valid && l < 40);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_bcd"}, bcd_out, 8'h00);
      check({tag, "_blank"}, blank, 0);
      check({tag, "_lz"}, lz_blank, 1);
      check({tag, "_src"}, src_sel, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_upd"}, upd_valid, 0);
   endtask

   // Monitor: every update must match the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && upd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_upd", 1, 0);
         end else begin
            e_bcd = exp_q.pop_front();
            check("bcd_out", bcd_out, e_bcd);
            check("lz_blank", lz_blank, e_bcd[7:4] == 4'd0);
         end
      end
   end

   initial begin
      rst = 1'b1; tick = 1'b0; mode = 2'd0;
      score_bin = 7'd0; time_bin = 7'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      repeat (3) step();
      check("idle_busy", busy, 0);

      // basic conversion and latency
      score_bin = 7'd42; exp_q.push_back(8'h42);
      wait_upd(lat); check("lat_42", lat, 9);
      step();
      score_bin = 7'd7; exp_q.push_back(8'h07);
      wait_upd(lat); check("lat_07", lat, 9);
      step();
      score_bin = 7'd120; exp_q.push_back(8'h99);
      wait_upd(lat); check("lat_sat", lat, 9);
      step();

      // change during the 3rd SHIFT cycle
      score_bin = 7'd5;
      exp_q.push_back(8'h05); exp_q.push_back(8'h06);
      repeat (4) step();
      check("busy_shift", busy, 1);
      check("no_partial", bcd_out, 8'h99);
      score_bin = 7'd6;
      drain();
      repeat (5) step();

      // alternate mode, tick every 3rd clock
      score_bin = 7'd12; exp_q.push_back(8'h12);
      drain();
      time_bin = 7'd34;
      step();
      mode = 2'd2;
      exp_src = 1'b0; tcnt = 0;
      for (int c = 0; c < 72; c++) begin
         @(posedge clk);
         if (tick) begin
            tcnt++;
            if (tcnt == 4) begin
               tcnt = 0;
               exp_src = ~exp_src;
               exp_q.push_back(exp_src ? 8'h34 : 8'h12);
            end
         end
         #1;
         check("alt_src", src_sel, exp_src);
         tick = (c % 3 == 2);
      end
      tick = 1'b0;
      drain();
      step();
      mode = 2'd0; exp_q.push_back(8'h12);
      step();
      check("mode0_src", src_sel, 0);
      drain();

      // game-over blink, tick every clock
      step();
      mode = 2'd3; tick = 1'b1;
      exp_blank = 1'b0; tcnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         tcnt++;
         if (tcnt == 3) begin
            tcnt = 0;
            exp_blank = ~exp_blank;
         end
         #1;
         check("blink", blank, exp_blank);
      end
      check("go_src", src_sel, 0);
      mode = 2'd0;
      step();
      check("blink_off", blank, 0);
      tick = 1'b0;
      repeat (3) step();

      // async reset in the middle of a conversion
      time_bin = 7'd88; mode = 2'd1;
      repeat (5) step();
      check("pre_rst_src", src_sel, 1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_reset("midrst");
      repeat (3) step();
      mode = 2'd0; score_bin = 7'd45;
      exp_q.push_back(8'h45);
      rst = 1'b0;
      wait_upd(lat); check("lat_post_rst", lat, 9);
      step();
      score_bin = 7'd3; exp_q.push_back(8'h03);
      wait_upd(lat); check("lat_03", lat, 9);
      drain();
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
